tl_cpl_gen: RTL and testbench

Completion generator on the TL transmit side. Consumes completion commands produced by the RX parser for received MRd/CfgRd and builds 3DW Cpl/CplD TLPs. Streams them as 128-bit beats toward the TX arbiter/DLL.

---
 rtl/tl_pkg.sv | 56 +++++
 rtl/tl_cpl_hdr_fmt.sv | 43 ++++
 rtl/tl_cpl_gen.sv | 116 +++++++++++
 tb/tb_tl_cpl_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared TL transmit types and the 3DW completion header packer.
// Header bytes are little-endian in the beat: byte n sits at bits [8n+7:8n].
package tl_pkg;

  localparam logic [2:0] CPL_SUCCESS    = 3'b000;
  localparam logic [2:0] CPL_UR         = 3'b001;
  localparam logic [2:0] CPL_CA         = 3'b100;
  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [4:0] TYPE_CPL       = 5'b01010;

  typedef struct packed {
    logic [15:0]  requester_id;
    logic [7:0]   tag;
    logic [11:0]  byte_count;
    logic [6:0]   lower_addr;
    logic [3:0]   first_be;
    logic [3:0]   last_be;
    logic [255:0] data;
    logic         has_data;
    logic [2:0]   cpl_status;
  } cpl_gen_cmd_t;

  typedef struct packed {
    logic [127:0] data;
    logic         sop;
    logic         eop;
  } tl_stream_t;

  function automatic logic [95:0] cpl_hdr_build(
    input logic [2:0]  fmt,
    input logic [9:0]  len,
    input logic [15:0] completer_id,
    input logic [2:0]  status,
    input logic [11:0] byte_count,
    input logic [15:0] requester_id,
    input logic [7:0]  tag,
    input logic [6:0]  lower_addr
  );
    logic [95:0] h;
    h        = '0;
    h[7:0]   = {fmt, TYPE_CPL};
    h[17:16] = len[9:8];
    h[31:24] = len[7:0];
    h[39:32] = completer_id[15:8];
    h[47:40] = completer_id[7:0];
    h[55:48] = {status, 1'b0, byte_count[11:8]};
    h[63:56] = byte_count[7:0];
    h[71:64] = requester_id[15:8];
    h[79:72] = requester_id[7:0];
    h[87:80] = tag;
    h[95:88] = {1'b0, lower_addr};
    return h;
  endfunction

endpackage

// File: rtl/tl_cpl_hdr_fmt.sv
// Combinational completion classifier: picks Cpl vs CplD, fixes up oversize
// requests to UR, and returns the header, payload length and last beat index.
module tl_cpl_hdr_fmt
  import tl_pkg::*;
#(
  parameter int MAX_PAYLOAD_DW = 8
) (
  input  cpl_gen_cmd_t cmd_i,
  input  logic [15:0]  completer_id_i,
  output logic [95:0]  hdr_o,
  output logic         is_data_o,
  output logic [3:0]   len_dw_o,
  output logic [1:0]   last_beat_o
);

  logic [12:0] bc_plus3;
  logic [10:0] len_calc;
  logic        oversize;
  logic [2:0]  status;
  logic [11:0] bc_field;
  logic [9:0]  len_field;
  logic [3:0]  last_beat_w;

  always_comb begin
    bc_plus3  = {1'b0, cmd_i.byte_count} + 13'd3;
    len_calc  = (cmd_i.byte_count == 12'd0) ? 11'd1 : bc_plus3[12:2];
    oversize  = cmd_i.has_data && (cmd_i.cpl_status == CPL_SUCCESS) &&
                (len_calc > 11'(MAX_PAYLOAD_DW));
    is_data_o = cmd_i.has_data && (cmd_i.cpl_status == CPL_SUCCESS) && !oversize;
    // An oversize read is refused as UR with no byte count rather than truncated.
    status    = oversize ? CPL_UR : cmd_i.cpl_status;
    bc_field  = oversize ? 12'd0 : cmd_i.byte_count;
    len_field = is_data_o ? len_calc[9:0] : 10'd0;
    len_dw_o  = is_data_o ? len_calc[3:0] : 4'd1;
    // Beat 0 holds DW0, each later beat four more: last = ceil((L-1)/4).
    last_beat_w = is_data_o ? ((len_calc[3:0] + 4'd2) >> 2) : 4'd0;
    last_beat_o = last_beat_w[1:0];
    hdr_o = cpl_hdr_build(is_data_o ? FMT_3DW_DATA : FMT_3DW_NODATA, len_field,
                          completer_id_i, status, bc_field, cmd_i.requester_id,
                          cmd_i.tag, cmd_i.lower_addr);
  end

endmodule

// File: rtl/tl_cpl_gen.sv
// Completion generator: one command in, a 3DW Cpl/CplD out as 128-bit beats.
// First beat one cycle after accept; beats hold stable while tl_tx_ready_i is low.
module tl_cpl_gen
  import tl_pkg::*;
#(
  parameter int MAX_PAYLOAD_DW = 8,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  cpl_gen_cmd_t     cpl_cmd_i,
  input  logic             cpl_cmd_valid_i,
  output logic             cpl_cmd_ready_o,
  input  logic [15:0]      completer_id_i,
  output tl_stream_t       tl_tx_o,
  output logic             tl_tx_valid_o,
  input  logic             tl_tx_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] cpl_sent_cnt_o
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

  state_e           state_q, state_d;
  cpl_gen_cmd_t     cmd_q, cmd_d;
  logic [15:0]      cid_q, cid_d;
  logic [1:0]       beat_q, beat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [95:0]  hdr;
  logic         is_data;
  logic [3:0]   len_dw;
  logic [1:0]   last_beat;
  logic [287:0] pay_ext;
  logic [3:0]   idx;

  tl_cpl_hdr_fmt #(.MAX_PAYLOAD_DW(MAX_PAYLOAD_DW)) u_hdr_fmt (
    .cmd_i          (cmd_q),
    .completer_id_i (cid_q),
    .hdr_o          (hdr),
    .is_data_o      (is_data),
    .len_dw_o       (len_dw),
    .last_beat_o    (last_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cid_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cid_q   <= cid_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cid_d   = cid_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpl_cmd_valid_i && cpl_cmd_ready_o) begin
          cmd_d   = cpl_cmd_i;
          cid_d   = completer_id_i;
          beat_d  = 2'd0;
          state_d = HDR;
        end
      end
      HDR, DATA: begin
        if (tl_tx_ready_i) begin
          if (tl_tx_o.eop) begin
            state_d = IDLE;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            state_d = DATA;
            beat_d  = beat_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat contents derive only from registered state, so they cannot move under a stall.
  always_comb begin
    pay_ext = {32'd0, cmd_q.data};
    idx     = 4'd0;
    tl_tx_o = '0;
    if (state_q != IDLE) begin
      tl_tx_o.sop = (beat_q == 2'd0);
      tl_tx_o.eop = (beat_q == last_beat);
      if (beat_q == 2'd0) begin
        tl_tx_o.data = {(is_data ? cmd_q.data[31:0] : 32'd0), hdr};
      end else begin
        for (int j = 0; j < 4; j++) begin
          idx = {beat_q, 2'b00} - 4'd3 + 4'(j);
          if (idx < len_dw) tl_tx_o.data[32*j +: 32] = pay_ext[32*idx +: 32];
        end
      end
    end
  end

  assign cpl_cmd_ready_o = (state_q == IDLE) && !rst;
  assign tl_tx_valid_o   = (state_q != IDLE);
  assign busy_o          = (state_q != IDLE);
  assign cpl_sent_cnt_o  = cnt_q;

endmodule

// File: tb/tb_tl_cpl_gen.sv
// Directed plus random completions checked beat by beat against a byte-level
// model of the completion format; stalls exercise hold and command blocking.
module tb_tl_cpl_gen;
  import tl_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  cpl_gen_cmd_t cmd;
  logic         cmd_vld;
  logic         cmd_rdy;
  logic [15:0]  cid;
  tl_stream_t   tx;
  logic         tx_vld;
  logic         tx_rdy;
  logic         busy;
  logic [15:0]  cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] sent     = '0;
  logic [129:0] exp_q[$];

  tl_cpl_gen #(.MAX_PAYLOAD_DW(8), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .cpl_cmd_i       (cmd),
    .cpl_cmd_valid_i (cmd_vld),
    .cpl_cmd_ready_o (cmd_rdy),
    .completer_id_i  (cid),
    .tl_tx_o         (tx),
    .tl_tx_valid_o   (tx_vld),
    .tl_tx_ready_i   (tx_rdy),
    .busy_o          (busy),
    .cpl_sent_cnt_o  (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-oriented completion built straight from the TLP rules.
  function automatic void model(input cpl_gen_cmd_t c, input logic [15:0] id);
    int          L, nb, idx, lenf;
    bit          ok, over;
    logic [2:0]  st;
    logic [11:0] bc;
    logic [7:0]  by[12];
    logic [129:0] beat;
    exp_q.delete();
    L    = (c.byte_count == 0) ? 1 : (int'(c.byte_count) + 3) / 4;
    over = c.has_data && (c.cpl_status == 3'b000) && (L > 8);
    ok   = c.has_data && (c.cpl_status == 3'b000) && !over;
    st   = over ? 3'b001 : c.cpl_status;
    bc   = over ? 12'd0 : c.byte_count;
    lenf = ok ? L : 0;
    for (int n = 0; n < 12; n++) by[n] = 8'h00;
    by[0]  = ok ? 8'h4A : 8'h0A;
    by[2]  = 8'((lenf >> 8) & 3);
    by[3]  = 8'(lenf & 255);
    by[4]  = id[15:8];
    by[5]  = id[7:0];
    by[6]  = {st, 1'b0, bc[11:8]};
    by[7]  = bc[7:0];
    by[8]  = c.requester_id[15:8];
    by[9]  = c.requester_id[7:0];
    by[10] = c.tag;
    by[11] = {1'b0, c.lower_addr};
    nb = ok ? 1 + (L - 1 + 3) / 4 : 1;
    for (int k = 0; k < nb; k++) begin
      beat = '0;
      if (k == 0) begin
        for (int n = 0; n < 12; n++) beat[2 + 8*n +: 8] = by[n];
        if (ok) beat[98 +: 32] = c.data[31:0];
      end else begin
        for (int j = 0; j < 4; j++) begin
          idx = 4*k - 3 + j;
          if (idx < L) beat[2 + 32*j +: 32] = c.data[32*idx +: 32];
        end
      end
      beat[1] = (k == 0);
      beat[0] = (k == nb - 1);
      exp_q.push_back(beat);
    end
  endfunction

  function automatic cpl_gen_cmd_t mk(input logic [15:0] rid, input logic [7:0] tag,
                                      input logic [11:0] bc, input logic [6:0] la,
                                      input logic [255:0] d, input logic hd,
                                      input logic [2:0] st);
    cpl_gen_cmd_t c;
    c = '0;
    c.requester_id = rid;
    c.tag          = tag;
    c.byte_count   = bc;
    c.lower_addr   = la;
    c.first_be     = 4'hF;
    c.last_be      = 4'hF;
    c.data         = d;
    c.has_data     = hd;
    c.cpl_status   = st;
    return c;
  endfunction

  function automatic cpl_gen_cmd_t rand_cmd();
    logic [255:0] d;
    logic [2:0]   st;
    logic [11:0]  bc;
    int           s;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    s  = $urandom_range(0, 5);
    st = (s == 4) ? 3'b001 : (s == 5) ? 3'b100 : 3'b000;
    bc = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 34));
    return mk(16'($urandom), 8'($urandom), bc, 7'($urandom), d,
              1'($urandom_range(0, 3) != 0), st);
  endfunction

  // Called at a negedge; returns at the negedge just after the eop handshake.
  task automatic run_cmd(input cpl_gen_cmd_t c, input logic [15:0] id,
                         input int st_hdr, input int st_data, input bit rnd);
    int n, stalls;
    model(c, id);
    cmd = c; cid = id; cmd_vld = 1'b1; tx_rdy = 1'b0;
    n = 0;
    while (!cmd_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 130'(n < 20), 130'd1);
    @(negedge clk);
    // Keep a different command pending; it must not be taken mid-packet.
    cmd = rand_cmd(); cid = 16'($urandom);
    for (int b = 0; b < exp_q.size(); b++) begin
      stalls = rnd ? $urandom_range(0, 2) : ((b == 0) ? st_hdr : st_data);
      for (int s = 0; s <= stalls; s++) begin
        tx_rdy = (s == stalls);
        chk("beat_vld", 130'(tx_vld), 130'd1);
        chk("beat_dat", tx, exp_q[b]);
        chk("cmd_rdy_busy", 130'(cmd_rdy), 130'd0);
        chk("busy", 130'(busy), 130'd1);
        @(negedge clk);
      end
    end
    tx_rdy = 1'b0; cmd_vld = 1'b0;
    sent = sent + 16'd1;
    chk("vld_after_eop", 130'(tx_vld), 130'd0);
    chk("cnt", 130'(cnt), 130'(sent));
    chk("rdy_after_eop", 130'(cmd_rdy), 130'd1);
  endtask

  initial begin
    cpl_gen_cmd_t c;
    logic [255:0] pat;
    rst = 1'b1; cmd = '0; cmd_vld = 1'b0; cid = '0; tx_rdy = 1'b0;
    pat = 256'hDEADBEEF_01234567_89ABCDEF_13579BDF_2468ACE0_0F1E2D3C_4B5A6978_5A5A5A5A;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 130'(cmd_rdy), 130'd0);
    chk("rst_vld", 130'(tx_vld), 130'd0);
    chk("rst_tx", tx, 130'd0);
    chk("rst_busy", 130'(busy), 130'd0);
    chk("rst_cnt", 130'(cnt), 130'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_post_rst", 130'(cmd_rdy), 130'd1);

    // Cpl without data
    run_cmd(mk(16'h0100, 8'h2A, 12'd4, 7'h00, pat, 1'b0, 3'b000), 16'h0008, 0, 0, 1'b0);
    // 1DW CplD
    run_cmd(mk(16'h0200, 8'h11, 12'd4, 7'h10, {224'd0, 32'hCAFEBABE}, 1'b1, 3'b000),
            16'h0008, 0, 0, 1'b0);
    // 8DW CplD, then the same with backpressure in HDR and DATA
    run_cmd(mk(16'h0300, 8'h22, 12'd32, 7'h00, pat, 1'b1, 3'b000), 16'h0010, 0, 0, 1'b0);
    run_cmd(mk(16'h0301, 8'h23, 12'd32, 7'h04, pat, 1'b1, 3'b000), 16'h0010, 5, 3, 1'b0);
    // Oversize -> UR, and CA with data -> Cpl
    run_cmd(mk(16'h0400, 8'h33, 12'd64, 7'h00, pat, 1'b1, 3'b000), 16'h0018, 0, 0, 1'b0);
    run_cmd(mk(16'h0500, 8'h44, 12'd16, 7'h00, pat, 1'b1, 3'b100), 16'h0018, 0, 0, 1'b0);
    // Byte count zero and non-multiple-of-4 lengths
    run_cmd(mk(16'h0600, 8'h55, 12'd0, 7'h03, pat, 1'b1, 3'b000), 16'h0020, 0, 0, 1'b0);
    run_cmd(mk(16'h0700, 8'h66, 12'd17, 7'h01, pat, 1'b1, 3'b000), 16'h0020, 1, 1, 1'b0);

    // Reset while an 8DW CplD sits in its first DATA beat
    c = mk(16'h0800, 8'h77, 12'd32, 7'h00, pat, 1'b1, 3'b000);
    model(c, 16'h0028);
    cmd = c; cid = 16'h0028; cmd_vld = 1'b1; tx_rdy = 1'b0;
    @(negedge clk);
    cmd_vld = 1'b0; tx_rdy = 1'b1;
    @(negedge clk);
    tx_rdy = 1'b0;
    chk("pre_rst_beat1", tx, exp_q[1]);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld", 130'(tx_vld), 130'd0);
    chk("mid_rst_busy", 130'(busy), 130'd0);
    chk("mid_rst_cnt", 130'(cnt), 130'd0);
    rst = 1'b0;
    sent = '0;
    @(negedge clk);
    run_cmd(mk(16'h0900, 8'h88, 12'd24, 7'h00, pat, 1'b1, 3'b000), 16'h0030, 0, 2, 1'b0);

    for (int i = 0; i < 60; i++) run_cmd(rand_cmd(), 16'($urandom), 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
